// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the fetch/decode instruction queue: field positions,
// widths, default geometry and the entry layout.
package if_id_queue_pkg;

    localparam int IFQ_DEPTH_DEFAULT = 4;
    localparam int IFQ_SKID_DEFAULT  = 1;

    localparam int XLEN     = 32;
    localparam int OPCODE_W = 6;
    localparam int FUNCT_W  = 6;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 16;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;

    localparam logic [XLEN-1:0] NOP_IR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } ifq_entry_t;

    function automatic logic [XLEN-1:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/ifq_field_decode.sv
// Splits an instruction word into its register/opcode/immediate fields.
module ifq_field_decode
    import if_id_queue_pkg::*;
(
    input  logic [XLEN-1:0]     ir,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [FUNCT_W-1:0]  funct,
    output logic [XLEN-1:0]     imm
);

    assign opcode = ir[OPCODE_LSB +: OPCODE_W];
    assign rs     = ir[RS_LSB +: REG_W];
    assign rt     = ir[RT_LSB +: REG_W];
    assign rd     = ir[RD_LSB +: REG_W];
    assign funct  = ir[FUNCT_LSB +: FUNCT_W];
    assign imm    = sign_ext_imm(ir[IMM_LSB +: IMM_W]);

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with skid-aware stall, flush on redirect
// and a sticky overflow flag for instructions that arrive while full.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT,
    parameter int SKID  = IFQ_SKID_DEFAULT,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_ir,
    input  logic                flush,
    output logic                stall,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_ir,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [REG_W-1:0]    out_rs,
    output logic [REG_W-1:0]    out_rt,
    output logic [REG_W-1:0]    out_rd,
    output logic [FUNCT_W-1:0]  out_funct,
    output logic [XLEN-1:0]     out_imm,
    output logic [CW-1:0]       count,
    output logic                overflow
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - SKID);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    ifq_entry_t    mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [CW-1:0] count_nxt;
    ifq_entry_t    head_entry;

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !flush;
    assign push      = in_valid && !flush && (!full || pop);
    assign drop      = in_valid && !flush && full && !pop;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + CNT_ONE;
                2'b01:   count_nxt = count - CNT_ONE;
                default: count_nxt = count;
            endcase
        end
    end

    // Control state: pointers, occupancy, registered stall, sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            stall    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            stall <= !flush && (count_nxt >= STALL_AT);
            if (drop) begin
                overflow <= 1'b1;
            end
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) begin
                    tail <= tail + PTR_ONE;
                end
                if (pop) begin
                    head <= head + PTR_ONE;
                end
            end
        end
    end

    // Storage is data only; stale contents are masked by the occupancy check
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{pc: in_pc, ir: in_ir};
        end
    end

    always_comb begin
        head_entry = '{pc: '0, ir: NOP_IR};
        if (out_valid) begin
            head_entry = mem[head];
        end
    end

    assign out_pc = head_entry.pc;
    assign out_ir = head_entry.ir;

    ifq_field_decode u_field_decode (
        .ir     (out_ir),
        .opcode (out_opcode),
        .rs     (out_rs),
        .rt     (out_rt),
        .rd     (out_rd),
        .funct  (out_funct),
        .imm    (out_imm)
    );

endmodule
